ama_riscv_decoder: RTL and testbench

AMA_RISCV_DECODER -- requirements
Module: ama_riscv_decoder

---
 rtl/ama_riscv_decoder_pkg.sv | 63 ++++++
 rtl/ama_riscv_decoder_ctrl.sv | 112 +++++++++++
 rtl/ama_riscv_decoder.sv | 157 +++++++++++++++
 tb/tb_ama_riscv_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_decoder_pkg.sv
// -----------------------------------------------------------------------------
// ama_riscv_decoder_pkg
// Shared constants for the ID-stage decoder and the immediate generator:
//   - IG_*  : immediate generator select codes
//   - PC_*  : PC mux select codes
//   - ALU_* : ALU operation codes (special values only; the rest are funct3)
//   - WB_*  : write-back mux select codes
//   - OPC_* : RV32I major opcodes (inst[6:2])
//   - dec_state_t : decoder FSM states
//   - is_rv32i_opcode() : membership test for the RV32I opcode set
// Optional feature macro used by the decoder: AMA_RISCV_ILLEGAL_INST_EN
// -----------------------------------------------------------------------------
package ama_riscv_decoder_pkg;

   localparam logic [2:0] IG_DISABLED = 3'b000;
   localparam logic [2:0] IG_I_TYPE   = 3'b001;
   localparam logic [2:0] IG_S_TYPE   = 3'b010;
   localparam logic [2:0] IG_B_TYPE   = 3'b011;
   localparam logic [2:0] IG_J_TYPE   = 3'b100;
   localparam logic [2:0] IG_U_TYPE   = 3'b101;

   localparam logic [1:0] PC_START = 2'b00;
   localparam logic [1:0] PC_PLUS4 = 2'b01;
   localparam logic [1:0] PC_ALU   = 2'b10;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_PASS_B = 4'b1111;

   localparam logic [1:0] WB_DMEM = 2'd0;
   localparam logic [1:0] WB_ALU  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   typedef enum logic [1:0] {
      RST_SEQ = 2'b00,
      RUN     = 2'b01,
      FLUSH   = 2'b10
   } dec_state_t;

   // FENCE and SYSTEM belong to RV32I even though this decoder treats them
   // as NOPs, so they are not flagged as illegal.
   function automatic logic is_rv32i_opcode(input logic [4:0] opc);
      case (opc)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
            is_rv32i_opcode = 1'b1;
         default:
            is_rv32i_opcode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ama_riscv_decoder_ctrl.sv
// -----------------------------------------------------------------------------
// ama_riscv_decoder_ctrl
// Purely combinational opcode -> control decode for one instruction.
// Ports:
//   inst        in  32  instruction to decode
//   ig_sel      out 3   immediate generator select
//   rf_we       out 1   register file write enable (gated by rd == x0)
//   alu_a_sel   out 1   0 rs1, 1 PC
//   alu_b_sel   out 1   0 rs2, 1 imm
//   alu_op_sel  out 4   ALU operation
//   dmem_en     out 1   data memory enable
//   dmem_we     out 1   data memory write enable
//   wb_sel      out 2   0 DMEM, 1 ALU, 2 PC+4
//   ctrl_flow   out 1   BRANCH, JAL or JALR
//   is_jump     out 1   JAL or JALR (unconditionally taken)
// Unknown opcodes decode to a NOP (no enables, immediate disabled).
// -----------------------------------------------------------------------------
module ama_riscv_decoder_ctrl
   import ama_riscv_decoder_pkg::*;
(
   input  logic [31:0] inst,
   output logic [2:0]  ig_sel,
   output logic        rf_we,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [3:0]  alu_op_sel,
   output logic        dmem_en,
   output logic        dmem_we,
   output logic [1:0]  wb_sel,
   output logic        ctrl_flow,
   output logic        is_jump
);

   logic [4:0] opc;
   logic [2:0] funct3;
   logic       writes_rd;

   assign opc    = inst[6:2];
   assign funct3 = inst[14:12];

   always_comb begin
      ig_sel     = IG_DISABLED;
      writes_rd  = 1'b0;
      alu_a_sel  = 1'b0;
      alu_b_sel  = 1'b1;
      alu_op_sel = ALU_ADD;
      dmem_en    = 1'b0;
      dmem_we    = 1'b0;
      wb_sel     = WB_ALU;
      ctrl_flow  = 1'b0;
      is_jump    = 1'b0;
      case (opc)
         OPC_OP: begin
            writes_rd  = 1'b1;
            alu_b_sel  = 1'b0;
            alu_op_sel = {inst[30], funct3};
         end
         OPC_OP_IMM: begin
            ig_sel     = IG_I_TYPE;
            writes_rd  = 1'b1;
            // inst[30] only selects SRAI; for other OP-IMM it is immediate data
            alu_op_sel = {inst[30] & (funct3 == 3'b101), funct3};
         end
         OPC_LOAD: begin
            ig_sel    = IG_I_TYPE;
            writes_rd = 1'b1;
            dmem_en   = 1'b1;
            wb_sel    = WB_DMEM;
         end
         OPC_STORE: begin
            ig_sel  = IG_S_TYPE;
            dmem_en = 1'b1;
            dmem_we = 1'b1;
         end
         OPC_BRANCH: begin
            ig_sel    = IG_B_TYPE;
            alu_a_sel = 1'b1;
            ctrl_flow = 1'b1;
         end
         OPC_JAL: begin
            ig_sel    = IG_J_TYPE;
            writes_rd = 1'b1;
            alu_a_sel = 1'b1;
            wb_sel    = WB_PC4;
            ctrl_flow = 1'b1;
            is_jump   = 1'b1;
         end
         OPC_JALR: begin
            ig_sel    = IG_I_TYPE;
            writes_rd = 1'b1;
            wb_sel    = WB_PC4;
            ctrl_flow = 1'b1;
            is_jump   = 1'b1;
         end
         OPC_LUI: begin
            ig_sel     = IG_U_TYPE;
            writes_rd  = 1'b1;
            alu_op_sel = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            ig_sel    = IG_U_TYPE;
            writes_rd = 1'b1;
            alu_a_sel = 1'b1;
         end
         default: ;
      endcase
   end

   // Writes to x0 are dropped here so the register file never sees them.
   assign rf_we = writes_rd & (inst[11:7] != 5'd0);

endmodule

// File: rtl/ama_riscv_decoder.sv
// -----------------------------------------------------------------------------
// ama_riscv_decoder
// ID-stage control: reset sequencing FSM plus zero-latency instruction decode.
// After rst the PC is held at its start value for RST_SEQ_CYCLES cycles. Each
// control-flow instruction stalls fetch for one cycle (FLUSH) in which the PC
// is redirected (taken) or advanced, and the wrong-path ID slot is cleared.
// Parameter: RST_SEQ_CYCLES (1..4) cycles in reset sequence after rst release
// Ports:
//   clk, rst (synchronous, active-high)
//   inst_id      in  32  instruction in ID
//   br_taken     in  1   branch compare result for inst_id
//   ig_sel 3, pc_sel 2, pc_we, stall_if, clear_id, rf_we, alu_a_sel,
//   alu_b_sel, alu_op_sel 4, dmem_en, dmem_we, wb_sel 2   (outputs)
//   illegal_inst, illegal_seen  (outputs, only with AMA_RISCV_ILLEGAL_INST_EN)
// -----------------------------------------------------------------------------
module ama_riscv_decoder
   import ama_riscv_decoder_pkg::*;
#(
   parameter int RST_SEQ_CYCLES = 3
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_id,
   input  logic        br_taken,
   output logic [2:0]  ig_sel,
   output logic [1:0]  pc_sel,
   output logic        pc_we,
   output logic        stall_if,
   output logic        clear_id,
   output logic        rf_we,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [3:0]  alu_op_sel,
   output logic        dmem_en,
   output logic        dmem_we,
`ifdef AMA_RISCV_ILLEGAL_INST_EN
   output logic [1:0]  wb_sel,
   output logic        illegal_inst,
   output logic        illegal_seen
`else
   output logic [1:0]  wb_sel
`endif
);

   localparam logic [1:0] CNT_LAST = 2'(RST_SEQ_CYCLES - 1);

   dec_state_t state_reg;
   logic [1:0] cnt_reg;
   logic       taken_q;

   logic [2:0] d_ig_sel;
   logic       d_rf_we;
   logic       d_alu_a_sel;
   logic       d_alu_b_sel;
   logic [3:0] d_alu_op_sel;
   logic       d_dmem_en;
   logic       d_dmem_we;
   logic [1:0] d_wb_sel;
   logic       d_ctrl_flow;
   logic       d_is_jump;

   ama_riscv_decoder_ctrl u_ctrl (
      .inst       (inst_id),
      .ig_sel     (d_ig_sel),
      .rf_we      (d_rf_we),
      .alu_a_sel  (d_alu_a_sel),
      .alu_b_sel  (d_alu_b_sel),
      .alu_op_sel (d_alu_op_sel),
      .dmem_en    (d_dmem_en),
      .dmem_we    (d_dmem_we),
      .wb_sel     (d_wb_sel),
      .ctrl_flow  (d_ctrl_flow),
      .is_jump    (d_is_jump)
   );

   // rst overrides the state so the reset-cycle outputs match RST_SEQ even
   // when rst arrives mid-FLUSH.
   logic in_run;
   assign in_run = !rst && (state_reg == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RST_SEQ;
         cnt_reg   <= 2'd0;
         taken_q   <= 1'b0;
      end else begin
         case (state_reg)
            RST_SEQ: begin
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= RUN;
                  cnt_reg   <= 2'd0;
               end else begin
                  cnt_reg <= cnt_reg + 2'd1;
               end
            end
            RUN: begin
               if (d_ctrl_flow) begin
                  taken_q   <= br_taken | d_is_jump;
                  state_reg <= FLUSH;
               end
            end
            FLUSH:   state_reg <= RUN;
            default: state_reg <= RST_SEQ;
         endcase
      end
   end

   always_comb begin
      // Safe idle values shared by RST_SEQ and FLUSH.
      ig_sel     = IG_DISABLED;
      pc_sel     = PC_START;
      pc_we      = 1'b1;
      stall_if   = 1'b1;
      clear_id   = 1'b1;
      rf_we      = 1'b0;
      alu_a_sel  = 1'b0;
      alu_b_sel  = 1'b0;
      alu_op_sel = ALU_ADD;
      dmem_en    = 1'b0;
      dmem_we    = 1'b0;
      wb_sel     = WB_ALU;
      if (in_run) begin
         ig_sel     = d_ig_sel;
         pc_sel     = PC_PLUS4;
         clear_id   = 1'b0;
         rf_we      = d_rf_we;
         alu_a_sel  = d_alu_a_sel;
         alu_b_sel  = d_alu_b_sel;
         alu_op_sel = d_alu_op_sel;
         dmem_en    = d_dmem_en;
         dmem_we    = d_dmem_we;
         wb_sel     = d_wb_sel;
         // Hold the PC one cycle until the target is resolved in FLUSH.
         pc_we      = !d_ctrl_flow;
         stall_if   = d_ctrl_flow;
      end else if (!rst && state_reg == FLUSH) begin
         pc_sel   = taken_q ? PC_ALU : PC_PLUS4;
         stall_if = 1'b0;
      end
   end

`ifdef AMA_RISCV_ILLEGAL_INST_EN
   logic illegal_seen_reg;

   assign illegal_inst = in_run &&
                         (!is_rv32i_opcode(inst_id[6:2]) || inst_id[1:0] != 2'b11);
   assign illegal_seen = illegal_seen_reg;

   always_ff @(posedge clk) begin
      if (rst)
         illegal_seen_reg <= 1'b0;
      else if (illegal_inst)
         illegal_seen_reg <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ama_riscv_decoder.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_decoder
// Directed vectors with hand-computed expectations for ama_riscv_decoder.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ama_riscv_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_id = 32'h0000_0013;
   logic        br_taken = 1'b0;
   logic [2:0]  ig_sel;
   logic [1:0]  pc_sel;
   logic        pc_we, stall_if, clear_id, rf_we, alu_a_sel, alu_b_sel;
   logic [3:0]  alu_op_sel;
   logic        dmem_en, dmem_we;
   logic [1:0]  wb_sel;
`ifdef AMA_RISCV_ILLEGAL_INST_EN
   logic        illegal_inst, illegal_seen;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ama_riscv_decoder #(.RST_SEQ_CYCLES(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_id    (inst_id),
      .br_taken   (br_taken),
      .ig_sel     (ig_sel),
      .pc_sel     (pc_sel),
      .pc_we      (pc_we),
      .stall_if   (stall_if),
      .clear_id   (clear_id),
      .rf_we      (rf_we),
      .alu_a_sel  (alu_a_sel),
      .alu_b_sel  (alu_b_sel),
      .alu_op_sel (alu_op_sel),
      .dmem_en    (dmem_en),
      .dmem_we    (dmem_we),
`ifdef AMA_RISCV_ILLEGAL_INST_EN
      .wb_sel       (wb_sel),
      .illegal_inst (illegal_inst),
      .illegal_seen (illegal_seen)
`else
      .wb_sel     (wb_sel)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle / reset-sequence output set.
   task automatic check_rst_outputs(input string tag);
      check({tag, ".pc_sel"},   32'(pc_sel),   32'h0);
      check({tag, ".stall_if"}, 32'(stall_if), 32'h1);
      check({tag, ".clear_id"}, 32'(clear_id), 32'h1);
      check({tag, ".pc_we"},    32'(pc_we),    32'h1);
      check({tag, ".rf_we"},    32'(rf_we),    32'h0);
      check({tag, ".dmem_en"},  32'(dmem_en),  32'h0);
      check({tag, ".ig_sel"},   32'(ig_sel),   32'h0);
   endtask

   // Packed decode view: {ig_sel, rf_we, alu_a, alu_b, alu_op, dmem_en, dmem_we, wb_sel}
   function automatic logic [14:0] dec_vec();
      return {ig_sel, rf_we, alu_a_sel, alu_b_sel, alu_op_sel, dmem_en, dmem_we, wb_sel};
   endfunction

   function automatic logic [14:0] exp_vec(input logic [2:0] ig, input logic we, input logic a,
                                           input logic b, input logic [3:0] op,
                                           input logic men, input logic mwe, input logic [1:0] wb);
      return {ig, we, a, b, op, men, mwe, wb};
   endfunction

   // Non-control-flow RUN instruction: decode plus PC advance.
   task automatic check_run(input string tag, input logic [31:0] inst, input logic [14:0] exp);
      inst_id = inst;
      #1;
      check({tag, ".dec"},      32'(dec_vec()), 32'(exp));
      check({tag, ".pc_sel"},   32'(pc_sel),    32'h1);
      check({tag, ".pc_we"},    32'(pc_we),     32'h1);
      check({tag, ".stall_if"}, 32'(stall_if),  32'h0);
      $display("[TB] run %-10s inst=0x%08h dec=0x%04h", tag, inst, dec_vec());
      step();
   endtask

   initial begin
      // Reset: one cycle with rst high, then 3 sequencing cycles.
      rst = 1'b1;
      inst_id = 32'h0050_0093;
      step();
      check_rst_outputs("rst_cycle");
      rst = 1'b0;
      #1;
      for (int i = 1; i <= 3; i++) begin
         check_rst_outputs($sformatf("rst_seq%0d", i));
         $display("[TB] rst_seq cycle %0d pc_sel=%0d stall_if=%0d", i, pc_sel, stall_if);
         step();
      end

      // Cycle 4: first RUN decode (addi x1,x0,5).
      check_run("addi", 32'h0050_0093, exp_vec(3'b001, 1, 0, 1, 4'h0, 0, 0, 2'd1));

      // BEQ taken -> stall, then redirect to ALU target.
      inst_id = 32'h0020_8463;
      br_taken = 1'b1;
      #1;
      check("beq.stall_if",  32'(stall_if),  32'h1);
      check("beq.pc_we",     32'(pc_we),     32'h0);
      check("beq.dec",       32'(dec_vec()), 32'(exp_vec(3'b011, 0, 1, 1, 4'h0, 0, 0, 2'd1)));
      $display("[TB] beq taken inst=0x%08h stall_if=%0d", inst_id, stall_if);
      step();
      inst_id = 32'h0050_0093;  // wrong-path instruction must be ignored
      br_taken = 1'b0;
      #1;
      check("beq_fl.pc_sel",   32'(pc_sel),   32'h2);
      check("beq_fl.clear_id", 32'(clear_id), 32'h1);
      check("beq_fl.rf_we",    32'(rf_we),    32'h0);
      check("beq_fl.pc_we",    32'(pc_we),    32'h1);
      check("beq_fl.stall_if", 32'(stall_if), 32'h0);
      check("beq_fl.ig_sel",   32'(ig_sel),   32'h0);
      $display("[TB] beq flush pc_sel=%0d clear_id=%0d", pc_sel, clear_id);
      step();

      // BEQ not taken -> FLUSH advances by 4.
      inst_id = 32'h0020_8463;
      #1;
      check("beq_nt.stall_if", 32'(stall_if), 32'h1);
      step();
      check("beq_nt_fl.pc_sel", 32'(pc_sel), 32'h1);
      $display("[TB] beq not-taken flush pc_sel=%0d", pc_sel);
      step();

      // Directed decode table.
      check_run("addi_x0",  32'h0010_0013, exp_vec(3'b001, 0, 0, 1, 4'h0, 0, 0, 2'd1));
      check_run("add",      32'h0020_81B3, exp_vec(3'b000, 1, 0, 0, 4'h0, 0, 0, 2'd1));
      check_run("sub",      32'h4020_81B3, exp_vec(3'b000, 1, 0, 0, 4'h8, 0, 0, 2'd1));
      check_run("srai",     32'h4030_D093, exp_vec(3'b001, 1, 0, 1, 4'hD, 0, 0, 2'd1));
      check_run("addi_neg", 32'hC000_0093, exp_vec(3'b001, 1, 0, 1, 4'h0, 0, 0, 2'd1));
      check_run("lw",       32'h0080_A283, exp_vec(3'b001, 1, 0, 1, 4'h0, 1, 0, 2'd0));
      check_run("sw",       32'h0020_A223, exp_vec(3'b010, 0, 0, 1, 4'h0, 1, 1, 2'd1));
      check_run("lui",      32'h1234_50B7, exp_vec(3'b101, 1, 0, 1, 4'hF, 0, 0, 2'd1));
      check_run("auipc",    32'h0000_1097, exp_vec(3'b101, 1, 1, 1, 4'h0, 0, 0, 2'd1));

      // Unknown opcode -> NOP, no FLUSH.
      inst_id = 32'h0000_007F;
      #1;
      check("bad.dec",      32'(dec_vec()), 32'(exp_vec(3'b000, 0, 0, 1, 4'h0, 0, 0, 2'd1)));
      check("bad.pc_sel",   32'(pc_sel),    32'h1);
      check("bad.stall_if", 32'(stall_if),  32'h0);
`ifdef AMA_RISCV_ILLEGAL_INST_EN
      check("bad.illegal_inst", 32'(illegal_inst), 32'h1);
      check("bad.seen_before",  32'(illegal_seen), 32'h0);
`endif
      $display("[TB] unknown inst=0x%08h treated as NOP", inst_id);
      step();
      inst_id = 32'h0000_0013;
      #1;
      check("bad_next.clear_id", 32'(clear_id), 32'h0);
      check("bad_next.pc_sel",   32'(pc_sel),   32'h1);
`ifdef AMA_RISCV_ILLEGAL_INST_EN
      check("bad_next.illegal_inst", 32'(illegal_inst), 32'h0);
      check("bad_next.illegal_seen", 32'(illegal_seen), 32'h1);
`endif
      step();

      // JALR x1,0(x2): always taken regardless of br_taken.
      inst_id = 32'h0001_00E7;
      br_taken = 1'b0;
      #1;
      check("jalr.dec",      32'(dec_vec()), 32'(exp_vec(3'b001, 1, 0, 1, 4'h0, 0, 0, 2'd2)));
      check("jalr.stall_if", 32'(stall_if),  32'h1);
      step();
      check("jalr_fl.pc_sel", 32'(pc_sel), 32'h2);
      $display("[TB] jalr flush pc_sel=%0d", pc_sel);
      step();

      // JAL then rst asserted during FLUSH.
      inst_id = 32'h0080_00EF;
      #1;
      check("jal.dec",      32'(dec_vec()), 32'(exp_vec(3'b100, 1, 1, 1, 4'h0, 0, 0, 2'd2)));
      check("jal.stall_if", 32'(stall_if),  32'h1);
      check("jal.pc_we",    32'(pc_we),     32'h0);
      step();
      rst = 1'b1;
      #1;
      check_rst_outputs("jal_fl_rst");
      $display("[TB] rst in flush pc_sel=%0d", pc_sel);
      step();
      rst = 1'b0;
      #1;
      check_rst_outputs("post_rst1");
`ifdef AMA_RISCV_ILLEGAL_INST_EN
      check("post_rst.illegal_seen", 32'(illegal_seen), 32'h0);
`endif
      step();
      check_rst_outputs("post_rst2");
      step();
      check_rst_outputs("post_rst3");
      step();

      // Back in RUN: a not-taken branch must not redirect.
      inst_id = 32'h0020_8463;
      br_taken = 1'b0;
      #1;
      check("rerun.stall_if", 32'(stall_if), 32'h1);
      step();
      check("rerun_fl.pc_sel", 32'(pc_sel), 32'h1);
      $display("[TB] post-reset branch flush pc_sel=%0d", pc_sel);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
